// File: rtl/cam_init_seq.sv
// Camera sensor power-up sequencer: waits for PLL lock, pulses sensor
// reset, then streams a register table to an I2C master with retries.
module cam_init_seq #(
   parameter int unsigned RST_HOLD_CYC = 500000,
   parameter int unsigned SETTLE_CYC   = 1000000,
   parameter int unsigned NUM_REGS     = 16,
   parameter logic [6:0]  DEV_ADDR     = 7'h3C,
   parameter int unsigned MAX_RETRY    = 2,
   parameter int unsigned MS_CYC       = 50000
) (
   input  logic        clk_50m,
   input  logic        rst_n,
   input  logic        start,
   input  logic        clk_locked,
   output logic        mipi_rst,
   output logic [7:0]  tbl_addr,
   input  logic [23:0] tbl_data,
   output logic        i2c_req,
   output logic [6:0]  i2c_dev,
   output logic [15:0] i2c_reg,
   output logic [7:0]  i2c_wdata,
   input  logic        i2c_ack,
   input  logic        i2c_err,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  err_idx
);

   localparam int unsigned DLY_MAX = 255 * MS_CYC;
   localparam int unsigned MAX_A   = (RST_HOLD_CYC > SETTLE_CYC) ?
                                     RST_HOLD_CYC : SETTLE_CYC;
   localparam int unsigned CNT_MAX = (MAX_A > DLY_MAX) ? MAX_A : DLY_MAX;
   localparam int          CW      = $clog2(CNT_MAX + 2);
   localparam int          RW      = $clog2(MAX_RETRY + 2);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_LOCK,
      S_RST_HOLD,
      S_SETTLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_DELAY,
      S_DONE,
      S_ERR
   } state_t;

   state_t          r_state, w_state;
   logic [CW-1:0]   r_cnt, w_cnt;
   logic [RW-1:0]   r_retry, w_retry;
   logic [7:0]      r_addr, w_addr;
   logic            r_req, w_req;
   logic [15:0]     r_reg, w_reg;
   logic [7:0]      r_wdata, w_wdata;
   logic            r_mipi, w_mipi;
   logic [7:0]      r_err_idx, w_err_idx;

   logic [CW-1:0]   w_dly;
   logic            w_cnt_end;
   logic            w_last;
   logic            w_live;

   // Down-counters terminate when they reach 1 (or load 0 -> one cycle).
   assign w_dly     = CW'(tbl_data[7:0]) * CW'(MS_CYC);
   assign w_cnt_end = (r_cnt <= CW'(1));
   assign w_last    = (({1'b0, r_addr} + 9'd1) == 9'(NUM_REGS));
   assign w_live    = (r_state == S_RST_HOLD) || (r_state == S_SETTLE) ||
                      (r_state == S_ISSUE)    || (r_state == S_WAIT_ACK) ||
                      (r_state == S_DELAY);

   assign mipi_rst  = r_mipi;
   assign tbl_addr  = r_addr;
   assign i2c_req   = r_req;
   assign i2c_dev   = DEV_ADDR;
   assign i2c_reg   = r_reg;
   assign i2c_wdata = r_wdata;
   assign busy      = !((r_state == S_IDLE) || (r_state == S_DONE) ||
                        (r_state == S_ERR));
   assign done      = (r_state == S_DONE);
   assign error     = (r_state == S_ERR);
   assign err_idx   = r_err_idx;

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_retry   <= '0;
         r_addr    <= '0;
         r_req     <= 1'b0;
         r_reg     <= '0;
         r_wdata   <= '0;
         r_mipi    <= 1'b0;
         r_err_idx <= '0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_retry   <= w_retry;
         r_addr    <= w_addr;
         r_req     <= w_req;
         r_reg     <= w_reg;
         r_wdata   <= w_wdata;
         r_mipi    <= w_mipi;
         r_err_idx <= w_err_idx;
      end
   end

   // Next-state logic; losing PLL lock mid-sequence restarts from scratch.
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_retry   = r_retry;
      w_addr    = r_addr;
      w_req     = r_req;
      w_reg     = r_reg;
      w_wdata   = r_wdata;
      w_mipi    = r_mipi;
      w_err_idx = r_err_idx;
      if (w_live && !clk_locked) begin
         w_state = S_WAIT_LOCK;
         w_req   = 1'b0;
         w_mipi  = 1'b0;
         w_addr  = '0;
         w_retry = '0;
         w_cnt   = '0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  w_state   = S_WAIT_LOCK;
                  w_mipi    = 1'b0;
                  w_addr    = '0;
                  w_err_idx = '0;
                  w_retry   = '0;
                  w_cnt     = '0;
                  w_req     = 1'b0;
               end
            end
            S_WAIT_LOCK: begin
               w_mipi = 1'b0;
               if (clk_locked) begin
                  w_state = S_RST_HOLD;
                  w_cnt   = CW'(RST_HOLD_CYC);
               end
            end
            S_RST_HOLD: begin
               if (w_cnt_end) begin
                  w_mipi  = 1'b1;
                  w_state = S_SETTLE;
                  w_cnt   = CW'(SETTLE_CYC);
               end else begin
                  w_cnt = r_cnt - CW'(1);
               end
            end
            S_SETTLE: begin
               if (w_cnt_end) begin
                  w_cnt   = '0;
                  w_state = (NUM_REGS == 0) ? S_DONE : S_ISSUE;
               end else begin
                  w_cnt = r_cnt - CW'(1);
               end
            end
            S_ISSUE: begin
               if (tbl_data[23:8] == 16'hFFFF) begin
                  w_state = S_DELAY;
                  w_cnt   = w_dly;
               end else begin
                  w_req   = 1'b1;
                  w_reg   = tbl_data[23:8];
                  w_wdata = tbl_data[7:0];
                  w_state = S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (i2c_err) begin
                  w_req = 1'b0;
                  if (r_retry < RW'(MAX_RETRY)) begin
                     w_retry = r_retry + RW'(1);
                     w_state = S_ISSUE;
                  end else begin
                     w_err_idx = r_addr;
                     w_mipi    = 1'b1;
                     w_state   = S_ERR;
                  end
               end else if (i2c_ack) begin
                  w_req   = 1'b0;
                  w_retry = '0;
                  w_addr  = r_addr + 8'd1;
                  w_state = w_last ? S_DONE : S_ISSUE;
               end
            end
            S_DELAY: begin
               if (w_cnt_end) begin
                  w_cnt   = '0;
                  w_retry = '0;
                  w_addr  = r_addr + 8'd1;
                  w_state = w_last ? S_DONE : S_ISSUE;
               end else begin
                  w_cnt = r_cnt - CW'(1);
               end
            end
            default: w_state = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_init_seq.sv
// Directed bench for cam_init_seq with a scripted I2C responder
// and a small register table model.
module tb_cam_init_seq;

   logic        clk_50m = 1'b0;
   logic        rst_n;
   logic        start;
   logic        clk_locked;
   logic        mipi_rst;
   logic [7:0]  tbl_addr;
   logic [23:0] tbl_data;
   logic        i2c_req;
   logic [6:0]  i2c_dev;
   logic [15:0] i2c_reg;
   logic [7:0]  i2c_wdata;
   logic        i2c_ack;
   logic        i2c_err;
   logic        busy;
   logic        done;
   logic        error;
   logic [7:0]  err_idx;

   logic [23:0] tbl [0:3];

   int n_tests = 0;
   int n_fail  = 0;

   int          nreq;
   int          stab_err;
   int          cyc;
   int          kind     [0:15];
   logic [15:0] log_reg  [0:15];
   logic [7:0]  log_wd   [0:15];
   logic [7:0]  log_addr [0:15];
   int          log_cyc  [0:15];

   cam_init_seq #(
      .RST_HOLD_CYC (10),
      .SETTLE_CYC   (5),
      .NUM_REGS     (3),
      .DEV_ADDR     (7'h3C),
      .MAX_RETRY    (2),
      .MS_CYC       (4)
   ) dut (
      .clk_50m    (clk_50m),
      .rst_n      (rst_n),
      .start      (start),
      .clk_locked (clk_locked),
      .mipi_rst   (mipi_rst),
      .tbl_addr   (tbl_addr),
      .tbl_data   (tbl_data),
      .i2c_req    (i2c_req),
      .i2c_dev    (i2c_dev),
      .i2c_reg    (i2c_reg),
      .i2c_wdata  (i2c_wdata),
      .i2c_ack    (i2c_ack),
      .i2c_err    (i2c_err),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_idx    (err_idx)
   );

   always #5 clk_50m = ~clk_50m;

   assign tbl_data = (tbl_addr < 8'd3) ? tbl[tbl_addr[1:0]] : 24'h0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_50m);
      #1;
   endtask

   task automatic clear_log();
      nreq     = 0;
      stab_err = 0;
      for (int i = 0; i < 16; i++) kind[i] = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_end(input int bound);
      int n;
      n = 0;
      while (!(done || error) && n < bound) begin
         tick();
         n++;
      end
      check("finish_in_time", 32'(n < bound), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_mipi"},  32'(mipi_rst),  32'd0);
      check({tag, "_req"},   32'(i2c_req),   32'd0);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_done"},  32'(done),      32'd0);
      check({tag, "_error"}, 32'(error),     32'd0);
      check({tag, "_addr"},  32'(tbl_addr),  32'd0);
      check({tag, "_eidx"},  32'(err_idx),   32'd0);
      check({tag, "_reg"},   32'(i2c_reg),   32'd0);
      check({tag, "_wdata"}, 32'(i2c_wdata), 32'd0);
   endtask

   // I2C slave model: logs each request, answers on its third cycle.
   initial begin : responder
      int   wcnt;
      int   cur;
      logic prev;
      i2c_ack = 1'b0;
      i2c_err = 1'b0;
      wcnt = 0;
      cur  = 0;
      prev = 1'b0;
      cyc  = 0;
      forever begin
         @(negedge clk_50m);
         cyc++;
         i2c_ack = 1'b0;
         i2c_err = 1'b0;
         if (i2c_req) begin
            if (!prev) begin
               cur  = nreq;
               wcnt = 0;
               if (nreq < 16) begin
                  log_reg[nreq]  = i2c_reg;
                  log_wd[nreq]   = i2c_wdata;
                  log_addr[nreq] = tbl_addr;
                  log_cyc[nreq]  = cyc;
                  nreq++;
               end
            end else if (cur < 16) begin
               if (i2c_reg !== log_reg[cur] || i2c_wdata !== log_wd[cur])
                  stab_err++;
            end
            if (tbl_addr >= 8'd3) stab_err++;
            wcnt++;
            if (wcnt == 3 && cur < 16) begin
               case (kind[cur])
                  0: i2c_ack = 1'b1;
                  1: i2c_err = 1'b1;
                  2: begin i2c_ack = 1'b1; i2c_err = 1'b1; end
                  default: ;
               endcase
            end
         end
         prev = i2c_req;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      int n;
      rst_n      = 1'b0;
      start      = 1'b0;
      clk_locked = 1'b1;
      tbl[0] = 24'h3008_82;
      tbl[1] = 24'h3103_11;
      tbl[2] = 24'h4800_24;
      tbl[3] = 24'h0;
      clear_log();
      repeat (3) tick();
      check_reset_vals("rst");
      check("dev_addr", 32'(i2c_dev), 32'h3C);
      rst_n = 1'b1;
      tick();

      // nominal run
      pulse_start();
      check("nom_busy", 32'(busy), 32'd1);
      n = 0;
      while (!mipi_rst && n < 50) begin tick(); n++; end
      check("rst_hold_len", n, 11);
      n = 0;
      while (!i2c_req && n < 50) begin tick(); n++; end
      check("settle_len", n, 6);
      wait_end(200);
      check("nom_done",  32'(done),     32'd1);
      check("nom_busy0", 32'(busy),     32'd0);
      check("nom_err",   32'(error),    32'd0);
      check("nom_mipi",  32'(mipi_rst), 32'd1);
      check("nom_nreq",  nreq,          3);
      check("nom_addr",  32'(tbl_addr), 32'd3);
      check("nom_r0",    32'({log_reg[0], log_wd[0]}), 32'h300882);
      check("nom_r1",    32'({log_reg[1], log_wd[1]}), 32'h310311);
      check("nom_r2",    32'({log_reg[2], log_wd[2]}), 32'h480024);
      check("nom_ack2req", log_cyc[1] - log_cyc[0], 4);
      check("nom_stable", stab_err, 0);

      // retry: entry 1 errors once
      clear_log();
      kind[1] = 1;
      pulse_start();
      check("rty_done_clr", 32'(done), 32'd0);
      wait_end(200);
      check("rty_done", 32'(done),  32'd1);
      check("rty_err",  32'(error), 32'd0);
      check("rty_nreq", nreq,       4);
      check("rty_a1",   32'(log_addr[1]), 32'd1);
      check("rty_a2",   32'(log_addr[2]), 32'd1);
      check("rty_a3",   32'(log_addr[3]), 32'd2);
      check("rty_stable", stab_err, 0);

      // abort: entry 2 errors three times
      clear_log();
      kind[2] = 1;
      kind[3] = 1;
      kind[4] = 1;
      pulse_start();
      wait_end(200);
      check("abt_err",  32'(error),    32'd1);
      check("abt_done", 32'(done),     32'd0);
      check("abt_eidx", 32'(err_idx),  32'd2);
      check("abt_mipi", 32'(mipi_rst), 32'd1);
      check("abt_busy", 32'(busy),     32'd0);
      check("abt_nreq", nreq,          5);
      repeat (20) tick();
      check("abt_noreq", nreq, 5);
      check("abt_stable", stab_err, 0);

      // delay entry in slot 1
      clear_log();
      tbl[1] = 24'hFFFF03;
      pulse_start();
      check("dly_err_clr",  32'(error),   32'd0);
      check("dly_eidx_clr", 32'(err_idx), 32'd0);
      wait_end(200);
      check("dly_done", 32'(done), 32'd1);
      check("dly_nreq", nreq,      2);
      check("dly_a1",   32'(log_addr[1]), 32'd2);
      check("dly_r1",   32'(log_reg[1]),  32'h4800);
      check("dly_gap",  log_cyc[1] - log_cyc[0], 17);
      tbl[1] = 24'h3103_11;

      // lock loss while entry 1 awaits its ack
      clear_log();
      kind[1] = 3;
      pulse_start();
      n = 0;
      while (nreq < 2 && n < 200) begin tick(); n++; end
      check("lck_req1", nreq, 2);
      clk_locked = 1'b0;
      tick();
      check("lck_req0",  32'(i2c_req),  32'd0);
      check("lck_mipi0", 32'(mipi_rst), 32'd0);
      check("lck_addr0", 32'(tbl_addr), 32'd0);
      check("lck_busy",  32'(busy),     32'd1);
      repeat (3) tick();
      clk_locked = 1'b1;
      wait_end(300);
      check("lck_done", 32'(done), 32'd1);
      check("lck_nreq", nreq,      5);
      check("lck_a2",   32'(log_addr[2]), 32'd0);
      check("lck_a3",   32'(log_addr[3]), 32'd1);
      check("lck_a4",   32'(log_addr[4]), 32'd2);
      clk_locked = 1'b0;
      repeat (3) tick();
      check("lck_idle_done", 32'(done),     32'd1);
      check("lck_idle_mipi", 32'(mipi_rst), 32'd1);
      clk_locked = 1'b1;

      // asynchronous reset in the middle of SETTLE
      clear_log();
      pulse_start();
      n = 0;
      while (!mipi_rst && n < 50) begin tick(); n++; end
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check_reset_vals("arst");
      tick();
      rst_n = 1'b1;
      tick();
      check("arst_idle", 32'(busy), 32'd0);

      // ack and err together: err wins
      clear_log();
      kind[1] = 2;
      kind[2] = 2;
      kind[3] = 2;
      pulse_start();
      wait_end(200);
      check("both_err",  32'(error),   32'd1);
      check("both_done", 32'(done),    32'd0);
      check("both_eidx", 32'(err_idx), 32'd1);
      check("both_nreq", nreq,         4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cam_init_seq.md
CAM_INIT_SEQ -- requirements
Module: cam_init_seq

Interface
REQ-001 The block SHALL have the following parameters:
- RST_HOLD_CYC, 500000; cycles mipi_rst is held low (10 ms at 50 MHz).
- SETTLE_CYC, 1000000; cycles waited after reset release before the first I2C write.
- NUM_REGS, 16; number of table entries, range 0..255.
- DEV_ADDR, 7'h3C; 7-bit sensor I2C address.
- MAX_RETRY, 2; retries per entry after an I2C error.
- MS_CYC, 50000; cycles per delay-entry unit (1 ms).

REQ-002 The block SHALL have the following ports:
- clk_50m  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the sequence.
- clk_locked  in  1  sensor clock (clk_24m) PLL locked.
- mipi_rst  out  1  sensor reset; 0 holds the sensor in reset.
- tbl_addr  out  8  config table index.
- tbl_data  in  24  {reg[15:0], val[7:0]}, combinational from tbl_addr.
- i2c_req  out  1  write request to the I2C master.
- i2c_dev  out  7  constant DEV_ADDR.
- i2c_reg  out  16  register address.
- i2c_wdata  out  8  write data.
- i2c_ack  in  1  one-cycle write-success pulse.
- i2c_err  in  1  one-cycle write-failure (NACK) pulse.
- busy  out  1  sequence in progress.
- done  out  1  sequence completed; held until the next start.
- error  out  1  sequence aborted; held until the next start.
- err_idx  out  8  table index of the failing entry.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_LOCK, RST_HOLD, SETTLE, ISSUE, WAIT_ACK, DELAY, DONE and ERR.
REQ-004 In IDLE, DONE or ERR, start=1 SHALL clear done, error and err_idx, force mipi_rst=0, clear tbl_addr, and enter WAIT_LOCK; busy SHALL be 1 from the next cycle.
REQ-005 start SHALL be ignored in all other states.
REQ-006 WAIT_LOCK SHALL hold mipi_rst=0 and go to RST_HOLD on the first cycle clk_locked=1.
REQ-007 RST_HOLD SHALL drive mipi_rst=1 exactly RST_HOLD_CYC cycles after entry, then enter SETTLE.
REQ-008 SETTLE SHALL last SETTLE_CYC cycles, then enter ISSUE, or DONE if NUM_REGS=0.
REQ-009 ISSUE with tbl_data[23:8]=16'hFFFF SHALL enter DELAY for tbl_data[7:0]*MS_CYC cycles (0 means zero wait, one cycle in DELAY) and SHALL NOT raise i2c_req.
REQ-010 Otherwise ISSUE SHALL register i2c_reg/i2c_wdata from tbl_data, assert i2c_req, and enter WAIT_ACK.
REQ-011 i2c_req, i2c_reg and i2c_wdata SHALL stay stable until i2c_ack or i2c_err is sampled; i2c_req SHALL deassert the following cycle.
REQ-012 i2c_ack, and DELAY expiry, SHALL increment tbl_addr and clear the retry count; when the incremented value equals NUM_REGS the FSM SHALL enter DONE, else ISSUE.
REQ-013 i2c_err with retry count < MAX_RETRY SHALL increment the retry count and re-enter ISSUE with the same tbl_addr.
REQ-014 i2c_err with retry count = MAX_RETRY SHALL latch err_idx=tbl_addr and enter ERR.
REQ-015 If i2c_ack and i2c_err are sampled in the same cycle, i2c_err SHALL take priority.
REQ-016 DONE SHALL drive done=1, busy=0 and mipi_rst=1.
REQ-017 ERR SHALL drive error=1, busy=0 and mipi_rst=1.
REQ-018 clk_locked=0 in RST_HOLD, SETTLE, ISSUE, WAIT_ACK or DELAY SHALL next cycle drop i2c_req, force mipi_rst=0, clear tbl_addr, the retry count and all counters, and enter WAIT_LOCK.
REQ-019 clk_locked=0 in IDLE, DONE or ERR SHALL have no effect.
REQ-020 Cycle counters SHALL be sized for the largest parameter/product and SHALL NOT wrap.
REQ-021 tbl_addr SHALL never exceed NUM_REGS-1 while driving a request.

Reset
REQ-022 rst_n=0 SHALL asynchronously force IDLE, mipi_rst=0, i2c_req=0, busy=0, done=0, error=0, tbl_addr=0, err_idx=0, i2c_reg=0, i2c_wdata=0, and clear all counters.
REQ-023 Outputs SHALL change only on clk_50m edges after rst_n deasserts.

Verification (RST_HOLD_CYC=10, SETTLE_CYC=5, NUM_REGS=3, MS_CYC=4)
REQ-024 Nominal run: clk_locked=1, start pulse, ack 3 cycles after each req -> mipi_rst rises 10 cycles after RST_HOLD entry; 3 reqs with table payloads; done=1, busy=0.
REQ-025 Retry: entry 1 gets err then ack -> entry 1 is issued twice, done=1, error=0.
REQ-026 Abort: entry 2 gets err 3 times -> error=1, err_idx=2, mipi_rst=1, no further req.
REQ-027 Delay entry: table[1]=24'hFFFF03 -> no req for entry 1, 12-cycle gap, entry 2 issued.
REQ-028 Lock loss: clk_locked=0 during WAIT_ACK -> i2c_req=0 and mipi_rst=0 next cycle; on relock the sequence restarts from tbl_addr=0.
REQ-029 rst_n pulse mid-SETTLE, and simultaneous ack+err -> all REQ-022 reset values; err path taken.
